mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter sharing one SRAM-like memory port between instruction fetch (IF) and load/store (MEM).
//  Registers the owner of each transaction and drives the existing 32-bit 2:1 select muxes for addr/wdata.
//  Routes addr_ok, data_ok and rdata back to the owning requester only.
//  Sits between the pipeline and the AXI bridge; one transaction outstanding at a time.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive data grants allowed while inst_req pending before inst is forced (>=1)
//  CNT_W         3  width of starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT
// PORTS
//  clk                      in   1   system clock, rising edge
//  resetn                   in   1   asynchronous active-low reset
//  inst_req                 in   1   IF request; held with its fields until inst_addr_ok
//  inst_wr, inst_size       in   1,2 IF write flag / size (0=byte,1=half,2=word)
//  inst_addr, inst_wdata    in   32  IF address / write data
//  inst_addr_ok             out  1   IF request accepted downstream
//  inst_data_ok             out  1   IF transaction complete; inst_rdata valid
//  inst_rdata               out  32  IF read data
//  data_req, data_wr        in   1   MEM request / write flag; same rules as inst_*
//  data_size                in   2   MEM access size
//  data_addr, data_wdata    in   32  MEM address / write data
//  data_addr_ok             out  1   MEM request accepted downstream
//  data_data_ok             out  1   MEM transaction complete; data_rdata valid
//  data_rdata               out  32  MEM read data
//  m_req, m_wr              out  1   downstream request / write flag
//  m_size                   out  2   downstream size
//  m_addr, m_wdata          out  32  downstream address / write data (muxed by owner)
//  m_addr_ok, m_data_ok     in   1   downstream handshake
//  m_rdata                  in   32  downstream read data
//  busy                     out  1   1 when state != IDLE
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, owner=INST, starve_cnt=0.
//    All outputs 0 except rdata outputs, which pass m_rdata.
//  - States: IDLE, ADDR (m_req=1, wait m_addr_ok), DATA (wait m_data_ok).
//  - Arbitration point: in IDLE, or in DATA on the m_data_ok cycle.
//    * data_req only -> grant DATA; inst_req only -> grant INST.
//    * Both set -> grant DATA, unless starve_cnt==STARVE_LIMIT -> grant INST.
//    * Grant registered: owner and state<=ADDR next edge; none pending -> IDLE.
//  - starve_cnt: +1 on each DATA grant while inst_req=1; cleared on any INST grant or when inst_req=0; saturates.
//  - ADDR: m_req=1; m_wr, m_size, m_addr, m_wdata = owner's fields, combinational via owner-selected muxes.
//    owner's *_addr_ok = m_addr_ok; other requester's addr_ok = 0.
//    m_addr_ok=1 -> DATA. m_data_ok in ADDR is ignored (protocol violation; flagged by assertion).
//  - DATA: m_req=0. owner's *_data_ok = m_data_ok; other requester's data_ok always 0.
//    Both *_rdata = m_rdata (consumers qualify with their own data_ok).
//  - Latency: IDLE request -> m_req 1 cycle later. Back-to-back: next m_req the cycle after m_data_ok (no IDLE bubble).
//  - Requester dropping req before addr_ok: undefined; arbiter holds ADDR until m_addr_ok regardless.
//  - Reset mid-transaction: returns to IDLE immediately; a late m_data_ok arriving in IDLE is dropped,
//    and no *_data_ok is raised.
//  - No combinational path from *_req to m_req; m_addr/m_wdata depend on the owner register and the owner's inputs only.
// STRUCTURE
//  - arb_defs.vh: `define ARB_IDLE/ARB_ADDR/ARB_DATA (2-bit), `define OWN_INST 1'b0, `define OWN_DATA 1'b1.
//  - Reuse mux_32 for m_addr and m_wdata (ctrl_sig = owner); small narrow muxes inline.
//  - Single always block for state/owner/starve_cnt; output decode combinational. No further sub-modules.
// TESTING
//  1. Reset, inst_req=1 addr=0xBFC00000 alone -> m_req next cycle with m_addr=0xBFC00000.
//     addr_ok/data_ok routed to inst only; m_rdata=0x3C080001 seen on inst_rdata with inst_data_ok.
//  2. inst_req and data_req (sw 0x12345678 @0x80001000) same cycle -> data granted first (m_wr=1, m_wdata=0x12345678).
//     Inst is granted on the cycle after data's m_data_ok, with no IDLE cycle.
//  3. data_req held high for 6 transactions with inst_req=1 -> exactly 4 data grants, then 1 inst grant, then data resumes.
//  4. m_addr_ok delayed 3 cycles, m_data_ok delayed 5 -> m_req held, fields stable, single data_ok pulse to owner only.
//  5. resetn pulsed low while in DATA, then stray m_data_ok -> state IDLE, busy=0, no *_data_ok pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM state and transaction owner encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_mux_32.sv
// 32-bit 2:1 select mux; ctrl_sig=1 selects in1.
module mux_32 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        ctrl_sig,
  output logic [31:0] mux_out
);

  assign mux_out = ctrl_sig ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store.
// One transaction outstanding; owner is registered at each arbitration point.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state, state_nxt;
  owner_e           owner, owner_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  logic        arb_point;
  logic        grant_data;
  logic        sel_data;
  logic [31:0] addr_sel, wdata_sel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ARB_IDLE;
      owner      <= OWN_INST;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Arbitrating on the m_data_ok cycle lets the next request start without an IDLE bubble.
  assign arb_point  = (state == ARB_IDLE) || ((state == ARB_DATA) && m_data_ok);
  assign grant_data = data_req && !(inst_req && (starve_cnt == LIMIT));

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    starve_cnt_nxt = starve_cnt;

    case (state)
      ARB_IDLE: ;
      ARB_ADDR: if (m_addr_ok) state_nxt = ARB_DATA;
      ARB_DATA: ;
      default:  state_nxt = ARB_IDLE;
    endcase

    if (arb_point) begin
      if (grant_data) begin
        state_nxt = ARB_ADDR;
        owner_nxt = OWN_DATA;
      end else if (inst_req) begin
        state_nxt = ARB_ADDR;
        owner_nxt = OWN_INST;
      end else begin
        state_nxt = ARB_IDLE;
      end
    end

    if (!inst_req) begin
      starve_cnt_nxt = '0;
    end else if (arb_point) begin
      if (!grant_data)
        starve_cnt_nxt = '0;
      else if (starve_cnt != LIMIT)
        starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  assign sel_data = (owner == OWN_DATA);

  mux_32 u_addr_mux (
    .in0      (inst_addr),
    .in1      (data_addr),
    .ctrl_sig (sel_data),
    .mux_out  (addr_sel)
  );

  mux_32 u_wdata_mux (
    .in0      (inst_wdata),
    .in1      (data_wdata),
    .ctrl_sig (sel_data),
    .mux_out  (wdata_sel)
  );

  always_comb begin
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = '0;
    m_addr       = '0;
    m_wdata      = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;

    if (state == ARB_ADDR) begin
      m_req        = 1'b1;
      m_wr         = sel_data ? data_wr : inst_wr;
      m_size       = sel_data ? data_size : inst_size;
      m_addr       = addr_sel;
      m_wdata      = wdata_sel;
      inst_addr_ok = !sel_data && m_addr_ok;
      data_addr_ok = sel_data && m_addr_ok;
    end

    if (state == ARB_DATA) begin
      inst_data_ok = !sel_data && m_data_ok;
      data_data_ok = sel_data && m_data_ok;
    end
  end

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;
  assign busy       = (state != ARB_IDLE);

  // Completion before acceptance is a downstream protocol violation.
  a_no_data_ok_in_addr: assert property (
    @(posedge clk) disable iff (!resetn) !((state == ARB_ADDR) && m_data_ok)
  );

endmodule
